// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Arbitrates two register-file writeback ports into a single write port and
// maintains a per-register "write outstanding" scoreboard.
//
// Port 0 (pipeline writeback) normally wins contention. Port 1 (multi-cycle
// unit) is forced to win once it has been denied STARVE_MAX cycles in a row.
// Accepted writes appear on the registered rf_* outputs one cycle later.
// Writes to register 0 are accepted but never enable the register file.
//
// Parameters
//   STARVE_MAX  consecutive denials of port 1 before it is forced (1..15)
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   wb0_valid/addr/data     port 0 write request
//   wb0_ready               port 0 grant (combinational)
//   wb1_valid/addr/data     port 1 write request
//   wb1_ready               port 1 grant (combinational)
//   pend_set, pend_addr     mark a register as having an outstanding write
//   rf_we/rf_waddr/rf_wdata registered register-file write port
//   busy                    scoreboard, bit n = register n write outstanding
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_addr,
  input  logic [31:0] wb0_data,
  output logic        wb0_ready,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_addr,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  input  logic        pend_set,
  input  logic [4:0]  pend_addr,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy
);

  logic [3:0]  starve_cnt_reg;
  logic [3:0]  starve_cnt_next;
  logic        force_p1;
  logic        grant0;
  logic        grant1;
  logic        xfer;
  logic [4:0]  xfer_addr;
  logic [31:0] xfer_data;

  logic        rf_we_reg;
  logic [4:0]  rf_waddr_reg;
  logic [31:0] rf_wdata_reg;

  // Register 0 is never tracked, so only bits 31..1 hold state.
  logic [31:1] busy_reg;
  logic [31:1] busy_next;

  // -------------------------------------------------------------------------
  // Grant selection and starvation counter
  // -------------------------------------------------------------------------
  always_comb begin
    force_p1        = (starve_cnt_reg == 4'(STARVE_MAX));
    grant0          = 1'b0;
    grant1          = 1'b0;
    starve_cnt_next = 4'd0;

    // No grants while reset is held, so nothing can transfer that cycle.
    if (!reset) begin
      if (wb0_valid && wb1_valid) begin
        grant1 = force_p1;
        grant0 = !force_p1;
      end else begin
        grant0 = wb0_valid;
        grant1 = wb1_valid;
      end
    end

    // Counter can never pass STARVE_MAX: at that value port 1 is granted.
    if (wb1_valid && !grant1) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end

    xfer      = grant0 | grant1;
    xfer_addr = grant1 ? wb1_addr : wb0_addr;
    xfer_data = grant1 ? wb1_data : wb0_data;
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Registered register-file write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= 5'd0;
      rf_wdata_reg <= 32'd0;
    end else begin
      // A write to r0 completes the handshake but is discarded here.
      rf_we_reg <= xfer && (xfer_addr != 5'd0);
      if (xfer) begin
        rf_waddr_reg <= xfer_addr;
        rf_wdata_reg <= xfer_data;
      end
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;

  // -------------------------------------------------------------------------
  // Scoreboard: a same-cycle pend_set beats the clearing writeback, so a
  // newly issued instruction's outstanding write is never lost.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (pend_set && (pend_addr == 5'(gi))) ||
                             (busy_reg[gi] && !(xfer && (xfer_addr == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy = {busy_reg, 1'b0};

endmodule
